// File: rtl/sync_filter_edge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_filter_edge_pkg
// Brief    : Shared limits and helpers for the synchronise/filter/edge block.
//            Holds the minimum legal chain depth and filter length and the
//            function that sizes the per-channel stability counter.
// Revision : 1.0 - initial release
// ============================================================================
package sync_filter_edge_pkg;

  // A single flop is not a synchroniser; two stages is the floor.
  localparam int c_sync_size_min = 2;

  // A filter length of 1 means "accept on first mismatch", i.e. no filtering.
  localparam int c_filt_cnt_min  = 1;

  // Counter must hold 0 .. filt_cnt-1; sized for filt_cnt+1 states so the
  // result is never zero-width, even when filt_cnt is 1.
  function automatic int cnt_width(input int filt_cnt);
    return (filt_cnt < 1) ? 1 : $clog2(filt_cnt + 1);
  endfunction

endpackage : sync_filter_edge_pkg
`default_nettype wire

// File: rtl/sync_filter_edge_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_filter_edge_if
// Brief    : Bundles the raw asynchronous levels and the conditioned
//            level/edge outputs of the input conditioner.
// Revision : 1.0 - initial release
// ============================================================================
interface sync_filter_edge_if #(
  parameter int NUM_CH = 4
);

  logic [NUM_CH-1:0] sig_a;   // raw asynchronous levels
  logic [NUM_CH-1:0] sig_b;   // filtered, synchronised levels
  logic [NUM_CH-1:0] rise_b;  // one-cycle 0->1 pulse on sig_b
  logic [NUM_CH-1:0] fall_b;  // one-cycle 1->0 pulse on sig_b

  // Source side: drives the raw levels, observes the conditioned outputs.
  modport master (
    output sig_a,
    input  sig_b,
    input  rise_b,
    input  fall_b
  );

  // Conditioner side.
  modport slave (
    input  sig_a,
    output sig_b,
    output rise_b,
    output fall_b
  );

endinterface : sync_filter_edge_if
`default_nettype wire

// File: rtl/sync_filter_edge_ff_sync_chain.sv
`default_nettype none
// ============================================================================
// Module   : ff_sync_chain
// Brief    : 1-bit, SYNC_SIZE-deep flop synchroniser with asynchronous
//            active-low reset to RST_VAL. Output is the last stage.
// Revision : 1.0 - initial release
// ============================================================================
module ff_sync_chain
  import sync_filter_edge_pkg::*;
#(
  parameter int   SYNC_SIZE = 2,
  parameter logic RST_VAL   = 1'b0
) (
  input  wire logic clk_b,
  input  wire logic rst_n,
  input  wire logic i_d,
  output logic      o_q
);

  if (SYNC_SIZE < c_sync_size_min) begin : g_bad_sync_size
    $error("ff_sync_chain: SYNC_SIZE must be at least %0d", c_sync_size_min);
  end

  logic [SYNC_SIZE-1:0] r_stage;

  // Shift the asynchronous level through the chain; stage 0 is the capture flop.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= {SYNC_SIZE{RST_VAL}};
    end else begin
      r_stage <= {r_stage[SYNC_SIZE-2:0], i_d};
    end
  end

  assign o_q = r_stage[SYNC_SIZE-1];

endmodule : ff_sync_chain
`default_nettype wire

// File: rtl/sync_filter_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_filter_edge
// Brief    : Multi-channel input conditioner. Each channel is synchronised
//            into clk_b, debounced by a consecutive-cycle stability filter,
//            and produces a clean level plus one-cycle rise/fall pulses.
//            Channels share nothing but clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_filter_edge
  import sync_filter_edge_pkg::*;
#(
  parameter int   NUM_CH    = 4,
  parameter int   SYNC_SIZE = 2,
  parameter int   FILT_CNT  = 4,
  parameter logic RST_VAL   = 1'b0
) (
  input  wire logic          clk_b,
  input  wire logic          rst_n,
  sync_filter_edge_if.slave  bus
);

  localparam int                 c_cnt_w    = cnt_width(FILT_CNT);
  // Count value on which a persistent mismatch is finally accepted.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILT_CNT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  if (FILT_CNT < c_filt_cnt_min) begin : g_bad_filt_cnt
    $error("sync_filter_edge: FILT_CNT must be at least %0d", c_filt_cnt_min);
  end

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("sync_filter_edge: NUM_CH must be at least 1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic               w_s;     // synchronised level (last chain stage)
    logic [c_cnt_w-1:0] r_cnt;   // consecutive mismatch cycles seen so far
    logic               r_sig;
    logic               r_rise;
    logic               r_fall;

    ff_sync_chain #(
      .SYNC_SIZE (SYNC_SIZE),
      .RST_VAL   (RST_VAL)
    ) u_sync (
      .clk_b (clk_b),
      .rst_n (rst_n),
      .i_d   (bus.sig_a[i]),
      .o_q   (w_s)
    );

    // Accept a new level only after it has differed from the output for
    // FILT_CNT consecutive cycles; any return to match discards the run.
    // Edge pulses are registered on the same edge the level flips.
    always_ff @(posedge clk_b or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt  <= '0;
        r_sig  <= RST_VAL;
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        if (w_s == r_sig) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_cnt  <= '0;
          r_sig  <= w_s;
          r_rise <= w_s;
          r_fall <= ~w_s;
        end else begin
          r_cnt <= r_cnt + c_cnt_one;
        end
      end
    end

    assign bus.sig_b[i]  = r_sig;
    assign bus.rise_b[i] = r_rise;
    assign bus.fall_b[i] = r_fall;
  end

endmodule : sync_filter_edge
`default_nettype wire

// File: doc/sync_filter_edge.md
# sync_filter_edge

Multi-channel input conditioner for asynchronous level signals entering the `clk_b` domain, and the parametrised successor to the single-bit flop synchroniser. Each of `NUM_CH` channels passes through a configurable-depth synchroniser chain, then a stability (debounce/glitch) filter. Each channel produces a clean level plus single-cycle rise/fall pulses. It sits at the boundary where pins, slow peripherals or foreign-clock status bits enter a clock domain.

## Interface
- `NUM_CH`, 4: number of independent channels, ≥1
- `SYNC_SIZE`, 2: synchroniser flop stages per channel, ≥2
- `FILT_CNT`, 4: consecutive `clk_b` cycles a new synchronised value must persist before `sig_b` accepts it, ≥1 (1 = no filtering)
- `RST_VAL`, 0: 1-bit reset value of every synchroniser stage and of `sig_b`, replicated across channels

- `clk_b`  in  1  destination-domain clock; all flops rising-edge
- `rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `sig_a`  in  NUM_CH  asynchronous input levels, no timing relation to `clk_b`
- `sig_b`  out  NUM_CH  filtered, synchronised levels
- `rise_b`  out  NUM_CH  one-cycle pulse when `sig_b[i]` goes 0→1
- `fall_b`  out  NUM_CH  one-cycle pulse when `sig_b[i]` goes 1→0

## Operation
- Channels are fully independent. There is no shared state between channels.
- Synchroniser: a `SYNC_SIZE`-deep shift chain per channel. Stage 0 samples `sig_a[i]`. `s[i]` denotes the last stage.
- Filter: one counter per channel, width `$clog2(FILT_CNT+1)`, reset 0.
  - Match state (`s[i] == sig_b[i]`): the counter clears to 0.
  - Mismatch state, counter `< FILT_CNT-1`: the counter increments.
  - Mismatch state, counter `== FILT_CNT-1`: `sig_b[i] <= s[i]`, the counter clears, and the matching edge pulse is registered.
- Any return to match before the threshold discards the count. A mismatch run shorter than `FILT_CNT` cycles never reaches `sig_b`.
- Counter saturation is impossible by construction; it never wraps.
- `rise_b[i]` / `fall_b[i]` are registered at the same edge that `sig_b[i]` changes. They are high for exactly one cycle, coincident with the new `sig_b` value. They are never both high on one channel.
- Reset (async assert, on `rst_n` falling):
  - all sync stages = `RST_VAL`
  - `sig_b` = {NUM_CH{RST_VAL}}
  - counters = 0
  - `rise_b` = `fall_b` = 0
- Reset mid-count discards the count. No pulse is emitted by reset itself.
- After reset release, an input differing from `RST_VAL` is processed as a normal transition and produces its pulse after the normal latency.

## Timing
- Edge numbering: edge 1 is the first `clk_b` rising edge that captures a stable new `sig_a` level into stage 0.
- `s[i]` changes at edge `SYNC_SIZE`.
- `sig_b[i]`, `rise_b[i]` and `fall_b[i]` change at edge `SYNC_SIZE + FILT_CNT`.
- Pulses clear at the following edge.
- Input metastability adds ±1 edge of uncertainty to the capture point only.
- All outputs are direct flop outputs, with no combinational path from `sig_a`.
- Reset deassertion must be synchronous to `clk_b`, handled upstream. Outputs update on the first edge after release.

## Structure
- Shared package/include holds:
  - the `SYNC_SIZE` minimum (2) and `FILT_CNT` minimum (1), enforced by elaboration-time checks
  - the counter-width function
- Sub-module `ff_sync_chain`: a 1-bit, `SYNC_SIZE`-deep, async-reset synchroniser with `RST_VAL`. It is instantiated `NUM_CH` times in a generate loop, with the filter and edge logic in the top level.

## Test plan
Unless stated, parameters are `NUM_CH=4`, `SYNC_SIZE=2`, `FILT_CNT=3`, `RST_VAL=0`.
- **Reset with input already high:** drive `sig_a=4'hF` with `rst_n=0`, then release and hold → `sig_b=0` during reset; `sig_b=4'hF` and `rise_b=4'hF` at edge 5 after release; `rise_b=0` at edge 6.
- **Glitch rejection:** from idle 0, raise `sig_a[0]` for exactly 2 cycles → `sig_b`, `rise_b` and `fall_b` stay 0 throughout; the counter returns to 0.
- **Falling edge:** after `sig_a[2]` has been high, drop it and hold → `sig_b[2]` falls and `fall_b[2]` pulses once at edge 5; `rise_b` stays 0.
- **Simultaneous opposite transitions:** at one edge, ch0 goes 0→1 and ch1 goes 1→0 → at edge 5, `rise_b=4'b0001` and `fall_b=4'b0010` in the same cycle; other channels are unaffected.
- **Reset mid-count:** assert `rst_n` asynchronously (between edges) after 2 mismatch cycles → all outputs reach reset values immediately, no pulse is emitted, and the counter is 0 after release.
- **Unfiltered deep chain:** `SYNC_SIZE=3`, `FILT_CNT=1`, step `sig_a[3]` 0→1 → `sig_b[3]` and `rise_b[3]` change at edge 4.
